// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
// Holds ALU operation codes, FSM state encodings, Op/Funct constants,
// datapath mux select codes and the decoded instruction-class record.
package mc_ctrl_pkg;

  // ALU operation codes driven on ALUOp
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_WB     = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_RS      = 2'd1;
  localparam logic [1:0] SRCA_IR      = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;
  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;
  localparam logic [1:0] REGDST_RA    = 2'd2;
  localparam logic [1:0] WD_ALU       = 2'd0;
  localparam logic [1:0] WD_MDR       = 2'd1;
  localparam logic [1:0] WD_PC        = 2'd2;
  localparam logic [1:0] NPC_ALU      = 2'd0;
  localparam logic [1:0] NPC_BRANCH   = 2'd1;
  localparam logic [1:0] NPC_JUMP     = 2'd2;
  localparam logic [1:0] NPC_JR       = 2'd3;

  // Instruction class flags; alu_op is the EXE operation for R-type and I-ALU
  typedef struct packed {
    logic       legal;
    logic       rtype;
    logic       jr;
    logic       ialu;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       bne;
    logic       j;
    logic       jal;
    logic       shamt;
    logic       sext;
    logic [3:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational Op/Funct to instruction-class decoder
// Ports:
//   op_i    [5:0] opcode field IR[31:26]
//   funct_i [5:0] function field IR[5:0]
//   dec_o         class flags, legality and EXE-stage ALU operation
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_RTYPE: begin
        dec_o.rtype = 1'b1;
        case (funct_i)
          F_ADD, F_ADDU: dec_o.alu_op = ALU_ADD;
          F_SUB, F_SUBU: dec_o.alu_op = ALU_SUB;
          F_AND:         dec_o.alu_op = ALU_AND;
          F_OR:          dec_o.alu_op = ALU_OR;
          F_NOR:         dec_o.alu_op = ALU_NOR;
          F_SLT:         dec_o.alu_op = ALU_SLT;
          F_SLTU:        dec_o.alu_op = ALU_SLTU;
          F_SLL: begin
            dec_o.alu_op = ALU_SLL;
            dec_o.shamt  = 1'b1;
          end
          F_SRL: begin
            dec_o.alu_op = ALU_SRL;
            dec_o.shamt  = 1'b1;
          end
          F_SLLV:        dec_o.alu_op = ALU_SLLV;
          F_SRLV:        dec_o.alu_op = ALU_SRLV;
          F_JR: begin
            dec_o.rtype = 1'b0;
            dec_o.jr    = 1'b1;
          end
          default:       dec_o.rtype = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_o.ialu   = 1'b1;
        dec_o.sext   = 1'b1;
        dec_o.alu_op = ALU_ADD;
      end
      OP_SLTI: begin
        dec_o.ialu   = 1'b1;
        dec_o.sext   = 1'b1;
        dec_o.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        dec_o.ialu   = 1'b1;
        dec_o.alu_op = ALU_AND;
      end
      OP_ORI: begin
        dec_o.ialu   = 1'b1;
        dec_o.alu_op = ALU_OR;
      end
      OP_LUI: begin
        dec_o.ialu   = 1'b1;
        dec_o.alu_op = ALU_LUI;
      end
      OP_LW:   dec_o.lw  = 1'b1;
      OP_SW:   dec_o.sw  = 1'b1;
      OP_BEQ:  dec_o.beq = 1'b1;
      OP_BNE:  dec_o.bne = 1'b1;
      OP_J:    dec_o.j   = 1'b1;
      OP_JAL:  dec_o.jal = 1'b1;
      default: dec_o.legal = 1'b0;
    endcase
    dec_o.legal = dec_o.rtype | dec_o.jr | dec_o.ialu | dec_o.lw | dec_o.sw |
                  dec_o.beq | dec_o.bne | dec_o.j | dec_o.jal;
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB)
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (illegal instruction halts).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   Op, Funct         IR[31:26] / IR[5:0]
//   Zero, MemReady    ALU zero flag (branch) / memory access complete
//   PCWrite, IRWrite, RegWrite, MemWrite, MemRead   datapath enables
//   IorD, ALUOp, ALUSrcA, ALUSrcB, EXTOp, RegDst, WDSel, NPCOp   mux controls
//   Illegal           unsupported instruction seen
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IorD,
  output logic [3:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       Illegal
);

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic [5:0] op_sel, funct_sel;
  dec_t       dec;
  logic       mem_rdy;

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  // DECODE sees the freshly loaded IR; later states use the copy captured
  // there so the instruction class is stable for the rest of its life.
  assign op_sel    = (state_q == S_DECODE) ? Op    : op_q;
  assign funct_sel = (state_q == S_DECODE) ? Funct : funct_q;

  mc_decode u_decode (
    .op_i    (op_sel),
    .funct_i (funct_sel),
    .dec_o   (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_e'(RESET_STATE);
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= Op;
        funct_q <= Funct;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    IorD     = 1'b0;
    ALUOp    = ALU_NOP;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RT;
    EXTOp    = 1'b0;
    RegDst   = REGDST_RT;
    WDSel    = WD_ALU;
    NPCOp    = NPC_ALU;
    Illegal  = 1'b0;
    // Outputs are forced idle while rst is high so an aborted instruction
    // cannot leave a write strobe on the bus during the reset cycle.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALU_ADD;
          if (mem_rdy) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          // ALU precomputes PC + (imm << 2) for a possible branch
          ALUSrcB = SRCB_IMM_SL2;
          EXTOp   = 1'b1;
          ALUOp   = ALU_ADD;
          if (!dec.legal) begin
            Illegal = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
          end else if (dec.rtype || dec.ialu) begin
            state_d = S_EXE;
          end else if (dec.lw || dec.sw) begin
            state_d = S_MEMADR;
          end else if (dec.beq || dec.bne) begin
            state_d = S_BRANCH;
          end else begin
            state_d = S_JUMP;
          end
        end
        S_EXE: begin
          ALUOp = dec.alu_op;
          if (dec.rtype) begin
            ALUSrcA = dec.shamt ? SRCA_IR : SRCA_RS;
            ALUSrcB = SRCB_RT;
          end else begin
            ALUSrcA = SRCA_RS;
            ALUSrcB = SRCB_IMM;
            EXTOp   = dec.sext;
          end
          state_d = S_WB;
        end
        S_WB: begin
          RegWrite = 1'b1;
          WDSel    = WD_ALU;
          RegDst   = dec.rtype ? REGDST_RD : REGDST_RT;
          state_d  = S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_IMM;
          EXTOp   = 1'b1;
          ALUOp   = ALU_ADD;
          state_d = dec.lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_rdy) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RT;
          WDSel    = WD_MDR;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_rdy) state_d = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_RT;
          ALUOp   = ALU_SUB;
          NPCOp   = NPC_BRANCH;
          PCWrite = (dec.beq & Zero) | (dec.bne & ~Zero);
          state_d = S_FETCH;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          NPCOp   = dec.jr ? NPC_JR : NPC_JUMP;
          if (dec.jal) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            WDSel    = WD_PC;
          end
          state_d = S_FETCH;
        end
        S_HALT: begin
          Illegal = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
`timescale 1ns/1ps
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic       Zero = 1'b0, MemReady = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD, EXTOp, Illegal;
  logic [3:0] ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, RegDst, WDSel, NPCOp;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .IorD(IorD), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .EXTOp(EXTOp), .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, irw, rw, mw, mr, ill, iord;
    logic [3:0] alu;
    logic [1:0] srca, srcb;
    logic ext;
    logic [1:0] regdst, wdsel, npc;
  } outv_t;

  // Expected output per cycle; m selects the fields the instruction defines.
  // 'stall' is the number of MemReady-low cycles before the state completes.
  typedef struct { outv_t v; outv_t m; int stall; } phase_t;

  localparam int K_R = 0, K_JR = 1, K_IALU = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6, K_ILL = 7;

  int checks = 0;
  int failures = 0;
  phase_t ph[$];

  function automatic phase_t mk();
    phase_t p;
    p.v = '0; p.m = '0; p.stall = 0;
    p.m.pcw = 1; p.m.irw = 1; p.m.rw = 1; p.m.mw = 1; p.m.mr = 1; p.m.ill = 1;
    return p;
  endfunction
  function automatic phase_t w_alu(phase_t p, logic [3:0] x);  p.v.alu = x;  p.m.alu = '1;  return p; endfunction
  function automatic phase_t w_srca(phase_t p, logic [1:0] x); p.v.srca = x; p.m.srca = '1; return p; endfunction
  function automatic phase_t w_srcb(phase_t p, logic [1:0] x); p.v.srcb = x; p.m.srcb = '1; return p; endfunction
  function automatic phase_t w_ext(phase_t p, logic x);        p.v.ext = x;  p.m.ext = 1'b1; return p; endfunction
  function automatic phase_t w_iord(phase_t p, logic x);       p.v.iord = x; p.m.iord = 1'b1; return p; endfunction
  function automatic phase_t w_rdst(phase_t p, logic [1:0] x); p.v.regdst = x; p.m.regdst = '1; return p; endfunction
  function automatic phase_t w_wd(phase_t p, logic [1:0] x);   p.v.wdsel = x; p.m.wdsel = '1; return p; endfunction
  function automatic phase_t w_npc(phase_t p, logic [1:0] x);  p.v.npc = x;  p.m.npc = '1;  return p; endfunction

  function automatic int kind(logic [5:0] op, logic [5:0] f);
    case (op)
      6'h00: case (f)
               6'h08: return K_JR;
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
               6'h00, 6'h02, 6'h04, 6'h06: return K_R;
               default: return K_ILL;
             endcase
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f: return K_IALU;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02, 6'h03: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] f);
    case (f)
      6'h20, 6'h21: return ALU_ADD;
      6'h22, 6'h23: return ALU_SUB;
      6'h24: return ALU_AND;
      6'h25: return ALU_OR;
      6'h27: return ALU_NOR;
      6'h2a: return ALU_SLT;
      6'h2b: return ALU_SLTU;
      6'h00: return ALU_SLL;
      6'h02: return ALU_SRL;
      6'h04: return ALU_SLLV;
      default: return ALU_SRLV;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(logic [5:0] op);
    case (op)
      6'h08, 6'h09: return ALU_ADD;
      6'h0a: return ALU_SLT;
      6'h0c: return ALU_AND;
      6'h0d: return ALU_OR;
      default: return ALU_LUI;
    endcase
  endfunction

  // Build the cycle-by-cycle expectation for one instruction.
  function automatic void build(logic [5:0] op, logic [5:0] f, logic z, int fst, int mst);
    phase_t p;
    int k;
    k = kind(op, f);
    ph.delete();
    p = mk(); p.v.mr = 1; p.v.irw = 1; p.v.pcw = 1;
    p = w_iord(p, 0); p = w_srca(p, 0); p = w_srcb(p, 1); p = w_alu(p, ALU_ADD); p = w_npc(p, 0);
    p.stall = fst; ph.push_back(p);
    p = mk(); p = w_srca(p, 0); p = w_srcb(p, 3); p = w_ext(p, 1); p = w_alu(p, ALU_ADD);
    p.v.ill = (k == K_ILL); ph.push_back(p);
    case (k)
      K_R: begin
        p = mk(); p = w_alu(p, r_alu(f)); p = w_srca(p, (f == 6'h00 || f == 6'h02) ? 2'd2 : 2'd1);
        p = w_srcb(p, 0); ph.push_back(p);
        p = mk(); p.v.rw = 1; p = w_rdst(p, 1); p = w_wd(p, 0); ph.push_back(p);
      end
      K_IALU: begin
        p = mk(); p = w_alu(p, i_alu(op)); p = w_srcb(p, 2);
        if (op != 6'h0f) begin
          p = w_srca(p, 1); p = w_ext(p, (op == 6'h08 || op == 6'h09 || op == 6'h0a));
        end
        ph.push_back(p);
        p = mk(); p.v.rw = 1; p = w_rdst(p, 0); p = w_wd(p, 0); ph.push_back(p);
      end
      K_LW, K_SW: begin
        p = mk(); p = w_srca(p, 1); p = w_srcb(p, 2); p = w_ext(p, 1); p = w_alu(p, ALU_ADD); ph.push_back(p);
        p = mk(); p = w_iord(p, 1); p.stall = mst;
        if (k == K_LW) p.v.mr = 1; else p.v.mw = 1;
        ph.push_back(p);
        if (k == K_LW) begin
          p = mk(); p.v.rw = 1; p = w_rdst(p, 0); p = w_wd(p, 1); ph.push_back(p);
        end
      end
      K_BR: begin
        p = mk(); p = w_srca(p, 1); p = w_srcb(p, 0); p = w_alu(p, ALU_SUB); p = w_npc(p, 1);
        p.v.pcw = (op == 6'h04) ? z : ~z; ph.push_back(p);
      end
      K_JR: begin
        p = mk(); p.v.pcw = 1; p = w_npc(p, 3); ph.push_back(p);
      end
      K_J: begin
        p = mk(); p.v.pcw = 1; p = w_npc(p, 2);
        if (op == 6'h03) begin p.v.rw = 1; p = w_rdst(p, 2); p = w_wd(p, 2); end
        ph.push_back(p);
      end
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin p = mk(); p.v.ill = 1; ph.push_back(p); end
`endif
      end
    endcase
  endfunction

  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] f,
                     input logic z, input int fst, input int mst);
    outv_t a, e;
    phase_t p;
    build(op, f, z, fst, mst);
    for (int i = 0; i < ph.size(); i++) begin
      p = ph[i];
      for (int s = 0; s <= p.stall; s++) begin
        @(posedge clk); #1;
        rst = 1'b0; Op = op; Funct = f; Zero = z; MemReady = (s == p.stall);
        @(negedge clk);
        e = p.v;
        if (s < p.stall) begin e.pcw = 1'b0; e.irw = 1'b0; end
        a = outv_t'({PCWrite, IRWrite, RegWrite, MemWrite, MemRead, Illegal, IorD, ALUOp,
                     ALUSrcA, ALUSrcB, EXTOp, RegDst, WDSel, NPCOp});
        checks++;
        if ((a & p.m) !== (e & p.m)) begin
          failures++;
          $display("FAIL %s op=%h funct=%h cycle %0d.%0d: outputs %h required %h (mask %h)",
                   nm, op, f, i + 1, s, a & p.m, e & p.m, p.m);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; MemReady = 1'b1; Op = 6'($urandom_range(63, 0));
      @(negedge clk);
      checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, Illegal} !== 5'b0 || ALUOp !== ALU_NOP) begin
        failures++;
        $display("FAIL reset_idle: writes=%b ill=%b aluop=%h required all 0 / %h",
                 {PCWrite, IRWrite, RegWrite, MemWrite}, Illegal, ALUOp, ALU_NOP);
      end
    end
    run("reset_then_addu", 6'h00, 6'h21, 1'b0, 0, 0);
  endtask

  task automatic test_alu_ops();
    run("sll", 6'h00, 6'h00, 1'b0, 0, 0);
    run("srlv", 6'h00, 6'h06, 1'b0, 1, 0);
    run("lui", 6'h0f, 6'h15, 1'b0, 0, 0);
    run("andi", 6'h0c, 6'h00, 1'b0, 0, 0);
    run("addi", 6'h08, 6'h3f, 1'b0, 0, 0);
  endtask

  task automatic test_mem();
    run("lw_stall3", 6'h23, 6'h00, 1'b0, 0, 3);
    run("sw_stall2", 6'h2b, 6'h00, 1'b0, 2, 2);
    run("lw_nostall", 6'h23, 6'h11, 1'b1, 0, 0);
  endtask

  task automatic test_branch_jump();
    run("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    run("beq_not", 6'h04, 6'h00, 1'b0, 0, 0);
    run("bne_not", 6'h05, 6'h00, 1'b1, 0, 0);
    run("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
    run("j", 6'h02, 6'h00, 1'b0, 0, 0);
    run("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    run("jr", 6'h00, 6'h08, 1'b0, 0, 0);
  endtask

  task automatic test_reset_abort();
    Op = 6'h2b; Funct = 6'h00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      rst = 1'b0; MemReady = (c < 3);
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if (MemWrite !== 1'b1) begin
          failures++;
          $display("FAIL sw_stall_memwrite: MemWrite=%b required 1", MemWrite);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; MemReady = 1'b1;
    @(negedge clk);
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0) begin
      failures++;
      $display("FAIL abort_writes: writes=%b required 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    run("after_abort", 6'h00, 6'h21, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run("illegal_op3f", 6'h3f, 6'h00, 1'b0, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    @(posedge clk); #1; rst = 1'b1;
`endif
    run("after_illegal", 6'h00, 6'h21, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[26] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c,
                            6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns[14] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
                            6'h00, 6'h02, 6'h04, 6'h06, 6'h08};
    logic [5:0] op, f;
    int idx;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(25, 0);
      op = ops[idx];
      f = (idx < 14) ? fns[idx] : 6'($urandom_range(63, 0));
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(9, 0) == 0) begin
        op = ($urandom_range(1, 0) == 0) ? 6'h3f : 6'h00;
        f = 6'h3f;
      end
`endif
      run("random", op, f, 1'($urandom_range(1, 0)), $urandom_range(3, 0), $urandom_range(3, 0));
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch_jump();
    test_reset_abort();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
